// File: rtl/nibble_seq_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and index sizing.
package nibble_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Nibble index width; never below one bit so NIBBLES=1 still has a counter.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_adder_seq_if.sv
// Start/busy/done handshake plus operand and result buses of the nibble adder.
interface nibble_adder_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/fourbitsadder.sv
// Plain 4-bit ripple-carry adder shared by every nibble of the sequencer.
module fourbitsadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic       cout,
  output logic [3:0] Sum_total
);

  logic [4:0] c;

  always_comb begin
    c         = '0;
    Sum_total = '0;
    c[0]      = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum_total[i] = a[i] ^ b[i] ^ c[i];
      c[i+1]       = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_adder_seq.sv
// Adds two 4*NIBBLES-bit operands one nibble per clock, LSB nibble first,
// reusing a single fourbitsadder with the carry held in a register.
module nibble_adder_seq
  import nibble_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  nibble_adder_seq_if.slave bus
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_merged;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_c;
  logic             busy_d;
  logic             done_d;

  // Nibble selection for the shared adder; acc_merged is acc with this nibble filled in.
  always_comb begin
    nib_a      = a_r[{idx, 2'b00} +: 4];
    nib_b      = b_r[{idx, 2'b00} +: 4];
    acc_merged = acc;
    acc_merged[{idx, 2'b00} +: 4] = nib_sum;
    last_c     = (idx == IDX_LAST);
  end

  fourbitsadder u_add (
    .a         (nib_a),
    .b         (nib_b),
    .Cin       (carry_r),
    .cout      (nib_cout),
    .Sum_total (nib_sum)
  );

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= busy_d;
      bus.done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last_c)    state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Operand capture, nibble accumulation and final result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry_r  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            carry_r <= bus.cin;
            idx     <= '0;
            acc     <= '0;
          end
        end
        ST_RUN: begin
          acc     <= acc_merged;
          carry_r <= nib_cout;
          if (last_c) begin
            bus.sum  <= acc_merged;
            bus.cout <= nib_cout;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_adder_seq.sv
// Directed bench for nibble_adder_seq: cycle-level reference model plus literal checks.
module tb_nibble_adder_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nibble_adder_seq_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_adder_seq #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: rem counts cycles left in the current operation.
  int           rem = 0;
  logic [W:0]   pend;
  logic [W:0]   exp_res;

  always @(posedge clk) begin
    if (rst) begin
      rem     <= 0;
      exp_res <= '0;
    end else if (rem == 0) begin
      if (bus.start) begin
        pend <= (W+1)'(bus.a) + (W+1)'(bus.b) + (W+1)'(bus.cin);
        rem  <= NIBBLES + 1;
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) exp_res <= pend;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(bus.busy), 32'(rem >= 2));
      chk("done", 32'(bus.done), 32'(rem == 1));
      chk("sum",  32'(bus.sum),  32'(exp_res[W-1:0]));
      chk("cout", 32'(bus.cout), 32'(exp_res[W]));
    end
  end

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic [15:0] es, input logic ec, input string tag);
    int n;
    bus.a = av; bus.b = bv; bus.cin = cv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"},   32'(n),                NIBBLES);
    chk({tag, "_sum"},       32'(bus.sum),          32'(es));
    chk({tag, "_cout"},      32'(bus.cout),         32'(ec));
    chk({tag, "_model_sum"}, 32'(exp_res[W-1:0]),   32'(es));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int last;
    int cyc;

    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_sum",  32'(bus.sum),  32'h0000);
      chk("rst_cout", 32'(bus.cout), 32'd0);
    end

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "wrap");
    run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "mix");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "max");

    // start during RUN is ignored
    bus.a = 16'h00FF; bus.b = 16'h0F01; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h1111; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        chk("ign_sum",  32'(bus.sum),  32'h1000);
        chk("ign_cout", 32'(bus.cout), 32'd0);
      end
    end
    chk("ign_done_count", 32'(dones), 32'd1);

    // Reset in the middle of an operation
    bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sum",  32'(bus.sum),  32'h0000);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "post_abort");

    // start held high re-triggers every NIBBLES+2 cycles
    bus.a = 16'h0D06; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    dones = 0; last = -1; cyc = 0;
    repeat (30) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
        chk("held_sum", 32'(bus.sum), 32'h0D07);
        if (last >= 0) chk("held_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
        dones++;
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(dones), 32'd5);
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
